// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order word requests, buffers
// returned instructions toward decode and discards responses made stale by a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jal_jump,
    input  logic [31:0] jal_target,
    input  logic        jalr_jump,
    input  logic [31:0] jalr_target,
    output logic        fetch_misaligned
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   fifo_pc_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_instr_d [FIFO_DEPTH];
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [31:0]   rq_pc_q [FIFO_DEPTH];
    logic [31:0]   rq_pc_d [FIFO_DEPTH];
    logic [PW-1:0] rq_wr_q, rq_wr_d;
    logic [PW-1:0] rq_rd_q, rq_rd_d;
    logic          misaligned_q, misaligned_d;

    logic          req_valid;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          redirect;
    logic [31:0]   redirect_target;

    // Credit: buffered entries plus in-flight requests never exceed the buffer size,
    // so every non-stale response is guaranteed a free slot.
    assign req_valid = ~rst & ((SW'(count_q) + SW'(outst_q)) < SW'(FIFO_DEPTH));
    assign req_fire  = req_valid & imem_req_ready;
    assign rsp_fire  = imem_rsp_valid & (outst_q != '0);
    assign redirect  = branch_taken | jal_jump | jalr_jump;
    assign push      = rsp_fire & ~redirect & (discard_q == '0);
    assign pop       = (count_q != '0) & if_ready;

    always_comb begin
        if (jalr_jump) begin
            redirect_target = jalr_target;
        end else if (jal_jump) begin
            redirect_target = jal_target;
        end else begin
            redirect_target = branch_target;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        count_d      = count_q;
        outst_d      = outst_q + CW'(req_fire) - CW'(rsp_fire);
        discard_d    = discard_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;
        rq_pc_d      = rq_pc_q;
        rq_wr_d      = rq_wr_q;
        rq_rd_d      = rq_rd_q;
        misaligned_d = 1'b0;

        if (req_fire) begin
            pc_d             = pc_q + 32'd4;
            rq_pc_d[rq_wr_q] = pc_q;
            rq_wr_d          = rq_wr_q + PW'(1);
        end
        if (rsp_fire) begin
            rq_rd_d = rq_rd_q + PW'(1);
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end
        if (push) begin
            fifo_pc_d[fifo_wr_q]    = rq_pc_q[rq_rd_q];
            fifo_instr_d[fifo_wr_q] = imem_rsp_data;
            fifo_wr_d               = fifo_wr_q + PW'(1);
        end
        if (pop) begin
            fifo_rd_d = fifo_rd_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect) begin
            pc_d         = {redirect_target[31:2], 2'b00};
            count_d      = '0;
            fifo_rd_d    = fifo_wr_q;
            discard_d    = outst_d;
            misaligned_d = (redirect_target[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            count_q      <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            rq_wr_q      <= '0;
            rq_rd_q      <= '0;
            misaligned_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
                rq_pc_q[i]      <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            rq_wr_q      <= rq_wr_d;
            rq_rd_q      <= rq_rd_d;
            misaligned_q <= misaligned_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= fifo_pc_d[i];
                fifo_instr_q[i] <= fifo_instr_d[i];
                rq_pc_q[i]      <= rq_pc_d[i];
            end
        end
    end

    assign imem_req_valid   = req_valid;
    assign imem_req_addr    = pc_q;
    assign if_valid         = (count_q != '0);
    assign if_instr         = fifo_instr_q[fifo_rd_q];
    assign if_pc            = fifo_pc_q[fifo_rd_q];
    assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, an instruction-stream
// reference model checked every cycle, and directed redirect/reset scenarios.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC   = 32'h0000_0100;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jal_jump;
    logic [31:0] jal_target;
    logic        jalr_jump;
    logic [31:0] jalr_target;
    logic        fetch_misaligned;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jal_jump(jal_jump), .jal_target(jal_target),
        .jalr_jump(jalr_jump), .jalr_target(jalr_target),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int nVectors   = 0;
    int nFail      = 0;
    int cyc        = 0;
    int lat        = 1;
    int reqCount   = 0;
    int nDelivered = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;
    memReq_t memQ[$];

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return (addr ^ 32'hDEAD_BEEF) + 32'h0001_2345;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // In-order memory: answers each accepted request `lat` cycles later, one per cycle.
    always begin
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (memQ.size() != 0 && memQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memData(memQ[0].addr);
            void'(memQ.pop_front());
        end
        #4;
        if (imem_req_valid && imem_req_ready) begin
            memQ.push_back('{addr: imem_req_addr, due: cyc + lat});
            reqCount++;
        end
        cyc++;
    end

    logic [31:0] expPc;
    logic [31:0] expReq;
    logic        misPend;
    logic [31:0] tgt;
    logic        redirectNow;

    // Reference: fetch stream is sequential from the last redirect target (or RESET_PC);
    // decode must see exactly that PC stream with memory's contents attached.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            expPc   = RESET_PC;
            expReq  = RESET_PC;
            misPend = 1'b0;
        end else begin
            checkOutput("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, misPend});
            if (imem_req_valid) begin
                checkOutput("imem_req_addr", imem_req_addr, expReq);
            end
            if (if_valid) begin
                checkOutput("if_pc", if_pc, expPc);
                checkOutput("if_instr", if_instr, memData(expPc));
                if (if_ready) begin
                    expPc = expPc + 32'd4;
                    nDelivered++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                expReq = expReq + 32'd4;
            end
            redirectNow = branch_taken | jal_jump | jalr_jump;
            tgt = jalr_jump ? jalr_target : (jal_jump ? jal_target : branch_target);
            if (redirectNow) begin
                expReq  = tgt & ~32'h3;
                expPc   = tgt & ~32'h3;
                misPend = (tgt[1:0] != 2'b00);
            end else begin
                misPend = 1'b0;
            end
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic br, input logic jal, input logic jalr,
                                 input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
        branch_taken  = br;
        jal_jump      = jal;
        jalr_jump     = jalr;
        branch_target = bt;
        jal_target    = jt;
        jalr_target   = jrt;
        nextCycle();
        branch_taken = 1'b0;
        jal_jump     = 1'b0;
        jalr_jump    = 1'b0;
    endtask

    task automatic waitIfValid(input string name);
        int n = 0;
        while (!if_valid && n < 50) begin
            nextCycle();
            n++;
        end
        if (!if_valid) begin
            checkOutput({name, " timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int r0;
        int n;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b1;
        branch_taken   = 1'b0;
        jal_jump       = 1'b0;
        jalr_jump      = 1'b0;
        branch_target  = 32'h0;
        jal_target     = 32'h0;
        jalr_target    = 32'h0;

        repeat (3) nextCycle();
        checkOutput("reset imem_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("reset imem_req_addr", imem_req_addr, 32'h0000_0100);
        checkOutput("reset if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("reset if_instr", if_instr, 32'h0);
        checkOutput("reset if_pc", if_pc, 32'h0);
        checkOutput("reset fetch_misaligned", {31'b0, fetch_misaligned}, 32'd0);

        // Sequential fetch with single-cycle memory.
        rst = 1'b0;
        repeat (2) nextCycle();
        checkOutput("first if_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("first if_pc", if_pc, 32'h0000_0100);
        checkOutput("first if_instr", if_instr, 32'hDEAE_E334);
        nextCycle();
        checkOutput("second if_pc", if_pc, 32'h0000_0104);
        repeat (20) nextCycle();

        // Decode stall: credit limits issue, nothing lost on release.
        if_ready = 1'b0;
        r0 = reqCount;
        repeat (10) nextCycle();
        checkOutput("stall imem_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("stall if_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("stall requests within depth", {31'b0, (reqCount - r0) <= FIFO_DEPTH}, 32'd1);
        if_ready = 1'b1;
        repeat (10) nextCycle();

        // Branch with two requests in flight on 3-cycle memory.
        lat = 3;
        n = 0;
        while (memQ.size() != 2 && n < 30) begin
            nextCycle();
            n++;
        end
        checkOutput("two in flight", memQ.size(), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0);
        checkOutput("branch req addr", imem_req_addr, 32'h0000_0200);
        waitIfValid("branch");
        checkOutput("branch if_pc", if_pc, 32'h0000_0200);
        repeat (8) nextCycle();

        // Redirect priority and misaligned target.
        lat = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0300, 32'h0);
        checkOutput("jal over branch addr", imem_req_addr, 32'h0000_0300);
        checkOutput("aligned no pulse", {31'b0, fetch_misaligned}, 32'd0);
        waitIfValid("jal");
        checkOutput("jal if_pc", if_pc, 32'h0000_0300);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0300, 32'h0000_0501);
        checkOutput("jalr over jal addr", imem_req_addr, 32'h0000_0500);
        checkOutput("misaligned pulse", {31'b0, fetch_misaligned}, 32'd1);
        nextCycle();
        checkOutput("misaligned one cycle", {31'b0, fetch_misaligned}, 32'd0);
        waitIfValid("jalr");
        checkOutput("jalr if_pc", if_pc, 32'h0000_0500);
        repeat (6) nextCycle();

        // PC wrap at top of address space.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC);
        checkOutput("wrap start addr", imem_req_addr, 32'hFFFF_FFFC);
        r0 = reqCount;
        n = 0;
        while (reqCount == r0 && n < 20) begin
            nextCycle();
            n++;
        end
        checkOutput("wrap next addr", imem_req_addr, 32'h0000_0000);
        repeat (8) nextCycle();

        // Reset with one request outstanding; its late response must be ignored.
        imem_req_ready = 1'b0;
        n = 0;
        while (memQ.size() != 0 && n < 20) begin
            nextCycle();
            n++;
        end
        lat = 3;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        repeat (2) nextCycle();
        rst = 1'b0;
        nextCycle();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midreset if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("midreset imem_req_valid", {31'b0, imem_req_valid}, 32'd0);
        nextCycle();
        rst = 1'b0;
        repeat (2) nextCycle();
        checkOutput("stale response ignored", {31'b0, if_valid}, 32'd0);
        imem_req_ready = 1'b1;
        lat = 1;
        waitIfValid("post reset");
        checkOutput("post reset if_pc", if_pc, 32'h0000_0100);
        repeat (15) nextCycle();

        checkOutput("deliveries observed", {31'b0, nDelivered >= 20}, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule
